// File: rtl/wpm_calculator.sv
// Words-per-minute calculator: counts completed words, converts the BCD stopwatch
// time into tenths of a second and divides words*600 by it with a restoring divider.
module wpm_calculator #(
    parameter int unsigned WORD_W = 11,
    parameter int unsigned TIME_W = 13,
    parameter int unsigned NUM_W  = 21
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic              clear,
    input  logic              word_complete,
    input  logic [3:0]        minutes,
    input  logic [3:0]        sec_high,
    input  logic [3:0]        sec_low,
    input  logic [3:0]        tenths,
    output logic [WORD_W-1:0] total_words,
    output logic [WORD_W-1:0] wpm,
    output logic              wpm_valid,
    output logic              busy
);

    // One extra bit so out-of-range BCD digits (up to 10665) cannot wrap.
    localparam int unsigned DEN_W = TIME_W + 1;
    localparam int unsigned REM_W = DEN_W + 1;
    localparam int unsigned CNT_W = $clog2(NUM_W);
    localparam logic [WORD_W-1:0] WORD_MAX = '1;
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(NUM_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DIV,
        DONE
    } state_t;

    state_t              state;
    state_t              state_next;
    logic                word_prev;
    logic [3:0]          tenths_prev;
    logic                pending;
    logic                pending_next;
    logic [DEN_W-1:0]    den_q;
    logic [DEN_W-1:0]    den_next;
    logic [DEN_W-1:0]    rem_q;
    logic [DEN_W-1:0]    rem_next;
    logic [NUM_W-1:0]    quo_q;
    logic [NUM_W-1:0]    quo_next;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    cnt_next;
    logic [WORD_W-1:0]   words_next;
    logic [WORD_W-1:0]   wpm_next;
    logic                wpm_valid_next;
    logic                busy_next;

    logic                word_count;
    logic                req;
    logic [DEN_W-1:0]    den_calc;
    logic [REM_W-1:0]    trial;
    logic                fits;
    logic [DEN_W-1:0]    rem_step;
    logic [NUM_W-1:0]    quo_step;

    // Request detection and operand conversion
    always_comb begin
        word_count = word_complete && !word_prev && run && (total_words != WORD_MAX);
        req        = word_count || (tenths != tenths_prev);
        words_next = total_words + WORD_W'(word_count);
        den_calc   = DEN_W'(minutes)  * DEN_W'(600)
                   + DEN_W'(sec_high) * DEN_W'(100)
                   + DEN_W'(sec_low)  * DEN_W'(10)
                   + DEN_W'(tenths);
    end

    // One restoring-division step: the dividend shifts out of quo_q MSB first
    // while quotient bits shift in at the bottom.
    always_comb begin
        trial    = {rem_q, quo_q[NUM_W-1]};
        fits     = (trial >= REM_W'(den_q));
        rem_step = fits ? DEN_W'(trial - REM_W'(den_q)) : DEN_W'(trial);
        quo_step = {quo_q[NUM_W-2:0], fits};
    end

    // Next-state and datapath control
    always_comb begin
        state_next     = state;
        pending_next   = pending;
        den_next       = den_q;
        rem_next       = rem_q;
        quo_next       = quo_q;
        cnt_next       = cnt_q;
        wpm_next       = wpm;
        wpm_valid_next = 1'b0;

        case (state)
            IDLE: begin
                if (req || pending) begin
                    state_next   = LOAD;
                    pending_next = 1'b0;
                end
            end
            LOAD: begin
                den_next = den_calc;
                quo_next = NUM_W'(total_words) * NUM_W'(600);
                rem_next = '0;
                cnt_next = '0;
                if (den_calc == '0) begin
                    state_next     = DONE;
                    wpm_next       = '0;
                    wpm_valid_next = 1'b1;
                end else begin
                    state_next = DIV;
                end
            end
            DIV: begin
                rem_next = rem_step;
                quo_next = quo_step;
                cnt_next = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BIT) begin
                    state_next     = DONE;
                    wpm_valid_next = 1'b1;
                    wpm_next       = (quo_step > NUM_W'(WORD_MAX)) ? WORD_MAX
                                                                   : WORD_W'(quo_step);
                end
            end
            DONE: begin
                if (pending) begin
                    state_next   = LOAD;
                    pending_next = 1'b0;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        // Requests while a calculation is in flight collapse into one follow-on run.
        if (req && (state != IDLE)) begin
            pending_next = 1'b1;
        end

        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            state       <= IDLE;
            word_prev   <= 1'b0;
            tenths_prev <= '0;
            pending     <= 1'b0;
            den_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            cnt_q       <= '0;
            total_words <= '0;
            wpm         <= '0;
            wpm_valid   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_next;
            word_prev   <= word_complete;
            tenths_prev <= tenths;
            pending     <= pending_next;
            den_q       <= den_next;
            rem_q       <= rem_next;
            quo_q       <= quo_next;
            cnt_q       <= cnt_next;
            total_words <= words_next;
            wpm         <= wpm_next;
            wpm_valid   <= wpm_valid_next;
            busy        <= busy_next;
        end
    end

endmodule

// File: tb/tb_wpm_calculator.sv
// Self-checking bench for wpm_calculator: table of timed WPM cases plus
// hand-written pending, clear and reset sequences, checked through a scoreboard.
module tb_wpm_calculator;

    localparam int unsigned WORD_W = 11;
    localparam int unsigned TIME_W = 13;
    localparam int unsigned NUM_W  = 21;

    logic              clk;
    logic              reset;
    logic              run;
    logic              clear;
    logic              word_complete;
    logic [3:0]        minutes;
    logic [3:0]        sec_high;
    logic [3:0]        sec_low;
    logic [3:0]        tenths;
    logic [WORD_W-1:0] total_words;
    logic [WORD_W-1:0] wpm;
    logic              wpm_valid;
    logic              busy;

    wpm_calculator #(
        .WORD_W(WORD_W),
        .TIME_W(TIME_W),
        .NUM_W (NUM_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .run          (run),
        .clear        (clear),
        .word_complete(word_complete),
        .minutes      (minutes),
        .sec_high     (sec_high),
        .sec_low      (sec_low),
        .tenths       (tenths),
        .total_words  (total_words),
        .wpm          (wpm),
        .wpm_valid    (wpm_valid),
        .busy         (busy)
    );

    typedef struct {
        int wpm;
        int cyc;
    } exp_t;

    typedef struct {
        int words;
        int m;
        int sh;
        int sl;
        int t;
        int exp_wpm;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[10];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   model_words = 0;
    int   cur_t = 0;
    int   n0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (wpm_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid: wpm=%0d at cycle %0d, none expected", wpm, cyc);
                end else begin
                    e = sb.pop_front();
                    check("wpm_value", int'(wpm), e.wpm);
                    check("valid_cycle", cyc, e.cyc);
                end
            end
        end
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        @(negedge clk);
        while ((sb.size() != 0 || busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0 || busy) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: outstanding=%0d busy=%0b, required 0 and 0", sb.size(), busy);
            sb.delete();
        end
    endtask

    task automatic do_clear();
        tick();
        clear = 1'b1;
        word_complete = 1'b0;
        minutes = 4'd0; sec_high = 4'd0; sec_low = 4'd0; tenths = 4'd0;
        tick();
        clear = 1'b0;
        model_words = 0;
        cur_t = 0;
    endtask

    // Only used while the time reads 0:00.0, so every counted word takes the 2-cycle zero path.
    task automatic word_pulse();
        tick();
        word_complete = 1'b1;
        if (run && model_words < 2047) begin
            model_words++;
            sb.push_back('{0, cyc + 2});
        end
        tick();
        tick();
        word_complete = 1'b0;
        tick();
        tick();
    endtask

    task automatic set_time(input int m, input int sh, input int sl, input int t, input int exp_wpm);
        int den;
        den = m * 600 + sh * 100 + sl * 10 + t;
        tick();
        minutes = 4'(m); sec_high = 4'(sh); sec_low = 4'(sl); tenths = 4'(t);
        if (t != cur_t) sb.push_back('{exp_wpm, cyc + ((den == 0) ? 2 : 23)});
        cur_t = t;
        wait_drain(60);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; clear = 1'b0; run = 1'b0; word_complete = 1'b0;
        minutes = 4'd0; sec_high = 4'd0; sec_low = 4'd0; tenths = 4'd0;

        vecs[0] = '{10,  1,  0,  0,  5,    9};
        vecs[1] = '{5,   0,  2,  9,  9,   10};
        vecs[2] = '{1,   9,  5,  9,  9,    0};
        vecs[3] = '{7,   0,  0,  0,  1, 2047};
        vecs[4] = '{100, 2,  0,  0,  1,   49};
        vecs[5] = '{3,   0,  0,  6,  3,   28};
        vecs[6] = '{0,   0,  0,  5,  5,    0};
        vecs[7] = '{20,  0,  0,  1,  2, 1000};
        vecs[8] = '{20,  0,  0, 15, 15,   72};
        vecs[9] = '{50, 15, 15, 15, 15,    2};

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        fork
            monitor();
        join_none

        // Idle after reset
        @(negedge clk);
        check("reset_total_words", int'(total_words), 0);
        check("reset_wpm", int'(wpm), 0);
        check("reset_valid", int'(wpm_valid), 0);
        check("reset_busy", int'(busy), 0);
        repeat (50) begin
            tick();
            @(negedge clk);
            check("idle_busy", int'(busy), 0);
        end
        check("idle_total_words", int'(total_words), 0);
        check("idle_wpm", int'(wpm), 0);

        // Table of words-then-time cases
        for (int i = 0; i < 10; i++) begin
            do_clear();
            run = 1'b1;
            for (int w = 0; w < vecs[i].words; w++) word_pulse();
            wait_drain(10);
            check("vec_total_words", int'(total_words), vecs[i].words);
            set_time(vecs[i].m, vecs[i].sh, vecs[i].sl, vecs[i].t, vecs[i].exp_wpm);
            check("vec_wpm_hold", int'(wpm), vecs[i].exp_wpm);
        end

        // Ten words, then 1:00.0 via a tenths change back to zero
        do_clear();
        for (int w = 0; w < 10; w++) word_pulse();
        set_time(0, 0, 0, 5, 1200);
        set_time(1, 0, 0, 0, 10);
        check("ten_words_total", int'(total_words), 10);

        // Words while run is low are ignored
        run = 1'b0;
        word_pulse();
        wait_drain(10);
        check("run_low_total", int'(total_words), 10);
        run = 1'b1;

        // Saturation of the word counter and of the result
        do_clear();
        for (int w = 0; w < 2050; w++) word_pulse();
        wait_drain(10);
        check("sat_total_words", int'(total_words), 2047);
        set_time(0, 0, 0, 1, 2047);

        // Request during DIV: second LOAD straight out of DONE at N+24, second DONE at N+46
        do_clear();
        for (int w = 0; w < 10; w++) word_pulse();
        set_time(0, 0, 0, 5, 1200);
        tick();
        tenths = 4'd0; minutes = 4'd1;
        n0 = cyc;
        sb.push_back('{10, n0 + 23});
        repeat (10) tick();
        minutes = 4'd2; tenths = 4'd5;
        cur_t = 5;
        sb.push_back('{4, n0 + 46});
        @(negedge clk);
        check("pending_busy", int'(busy), 1);
        wait_drain(80);

        // Clear in the middle of DIV aborts without a valid pulse
        tick();
        tenths = 4'd6;
        n0 = cyc;
        repeat (14) tick();
        @(negedge clk);
        check("busy_before_clear", int'(busy), 1);
        tick();
        clear = 1'b1;
        minutes = 4'd0; sec_high = 4'd0; sec_low = 4'd0; tenths = 4'd0;
        tick();
        clear = 1'b0;
        model_words = 0;
        cur_t = 0;
        @(negedge clk);
        check("clear_busy", int'(busy), 0);
        check("clear_wpm", int'(wpm), 0);
        check("clear_total_words", int'(total_words), 0);
        check("clear_valid", int'(wpm_valid), 0);
        repeat (30) tick();

        // A level held high counts exactly once
        tick();
        word_complete = 1'b1;
        sb.push_back('{0, cyc + 2});
        repeat (19) tick();
        word_complete = 1'b0;
        wait_drain(10);
        check("held_level_total", int'(total_words), 1);

        // Reset and clear together mid-calculation
        tick();
        tenths = 4'd3;
        repeat (5) tick();
        reset = 1'b1; clear = 1'b1;
        tenths = 4'd0;
        tick();
        reset = 1'b0; clear = 1'b0;
        @(negedge clk);
        check("both_busy", int'(busy), 0);
        check("both_total_words", int'(total_words), 0);
        check("both_wpm", int'(wpm), 0);
        repeat (30) tick();

        check("scoreboard_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
